data_memory: RTL and testbench



---
 rtl/data_memory.sv | 68 ++++++
 tb/tb_data_memory.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module      : data_memory
// Description : Byte-wide data memory for the CSD processor datapath.
//               DEPTH locations of DATA_WIDTH bits. Writes happen on the
//               rising clock edge. Reads are combinational from addr.
//               Out-of-range accesses never alias: writes are dropped and
//               reads return zero.
// Ports       : clk      - system clock; writes occur on its rising edge
//               rst_n    - asynchronous active-low reset; clears all locations
//               write_en - write strobe, sampled at the rising clk edge
//               addr     - 16-bit byte address for both read and write
//               data_in  - 16-bit store data; only the low byte is stored
//               data_out - contents of mem[addr], or 0 when out of range
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory #(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_en,
  input  logic [15:0]           addr,
  input  logic [15:0]           data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so that DEPTH = 65536 still compares correctly.
  localparam logic [16:0] C_DEPTH = 17'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  w_in_range;
  logic [IDX_W-1:0]      w_idx;

  // The full 16-bit address is range-checked before the truncated index is
  // used, so high address bits can never wrap onto a low location.
  assign w_in_range = ({1'b0, addr} < C_DEPTH);
  assign w_idx      = addr[IDX_W-1:0];

  // The store-data high byte has no destination.
  logic unused_data_hi;
  assign unused_data_hi = &{1'b0, data_in[15:DATA_WIDTH]};

  // Whole array is cleared asynchronously; a write edge that coincides with
  // reset is therefore lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write_en && w_in_range) begin
      mem[w_idx] <= data_in[DATA_WIDTH-1:0];
    end
  end

  // Memory contents are already zero during reset, so no extra gating on
  // rst_n is needed to return zero for every address.
  always_comb begin
    data_out = '0;
    if (w_in_range) begin
      data_out = mem[w_idx];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory
// Description : Scoreboard testbench for data_memory. Stimulus pushes the
//               expected data_out into a queue and fires a sample event; an
//               independent monitor pops and compares. Expected values come
//               from a plain array reference model of the memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory;

  localparam int DEPTH = 256;

  logic        clk;
  logic        rst_n;
  logic        write_en;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [7:0]  data_out;

  data_memory #(.DEPTH(DEPTH), .DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .write_en (write_en),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  byte unsigned ref_mem [DEPTH];

  function automatic byte unsigned model_read(input int a);
    if (a < DEPTH) return ref_mem[a];
    return 8'h00;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    byte unsigned exp;
    string        name;
    int           a;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   checks   = 0;
  int   failures = 0;

  // Monitor: samples data_out 1 time unit after each request so the
  // combinational read path has settled.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sample_without_expectation got=%02h", data_out);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (data_out !== e.exp) begin
          failures++;
          $display("FAIL %s addr=%0d got=%02h expected=%02h", e.name, e.a, data_out, e.exp);
        end
      end
    end
  end

  task automatic expect_now(input string name);
    exp_t e;
    e.exp  = model_read(int'(addr));
    e.name = name;
    e.a    = int'(addr);
    exp_q.push_back(e);
    -> sample_ev;
  endtask

  // Read-only cycle: drive address at the falling edge and check.
  task automatic read_check(input int a, input string name);
    @(negedge clk);
    write_en = 1'b0;
    addr     = 16'(a);
    data_in  = 16'($urandom);
    expect_now(name);
  endtask

  // Write cycle, also checking read-during-write: old data before the edge,
  // new data after it.
  task automatic write_op(input int a, input logic [15:0] d, input string name);
    @(negedge clk);
    write_en = 1'b1;
    addr     = 16'(a);
    data_in  = d;
    expect_now({name, "_before_edge"});
    @(posedge clk);
    if (rst_n && a < DEPTH) ref_mem[a] = d[7:0];
    #1;
    expect_now({name, "_after_edge"});
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a;
    int op;
    write_en = 1'b0;
    addr     = 16'd0;
    data_in  = 16'd0;
    rst_n    = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    // Reset state visible while still in reset
    #1 addr = 16'd7;
    expect_now("in_reset_read");
    @(negedge clk);
    rst_n = 1'b1;

    read_check(0,   "reset_addr0");
    read_check(2,   "reset_addr2");
    read_check(5,   "reset_addr5");
    read_check(255, "reset_addr255");

    write_op(2, 16'd25, "wr2");
    read_check(2, "rd2");
    write_op(5, 16'd50, "wr5");
    read_check(5, "rd5");
    read_check(2, "rd2_kept");

    write_op(10, 16'hAB37, "wr_hibyte");
    read_check(10, "rd_hibyte_ignored");

    // Write disabled for several edges
    @(negedge clk);
    write_en = 1'b0;
    addr     = 16'd2;
    data_in  = 16'd99;
    repeat (3) @(posedge clk);
    #1 expect_now("we0_holds");
    #2;

    write_op(300, 16'h005A, "wr_oor");
    read_check(300, "rd_oor");
    read_check(44,  "rd_no_alias");
    write_op(16'hFFFF, 16'h00C3, "wr_max_addr");
    read_check(255, "rd255_after_max");

    // Back-to-back overwrite
    write_op(3, 16'd7, "wr3_a");
    write_op(3, 16'd9, "wr3_b");
    read_check(3, "rd3_last_wins");

    // Reset mid-cycle, with a write edge while in reset
    @(negedge clk);
    write_en = 1'b0;
    addr     = 16'd3;
    #2 rst_n = 1'b0;
    model_clear();
    expect_now("async_clear");
    @(negedge clk);
    write_en = 1'b1;
    data_in  = 16'd77;
    @(posedge clk);
    #1 expect_now("write_blocked_in_reset");
    @(negedge clk);
    write_en = 1'b0;
    rst_n    = 1'b1;
    read_check(3,  "rd3_after_reset");
    read_check(10, "rd10_after_reset");

    // First edge after release accepts a write
    write_op(3, 16'd33, "wr_first_after_reset");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) a = $urandom_range(DEPTH, 65535);
      else                           a = $urandom_range(0, DEPTH - 1);
      if (op < 5) write_op(a, 16'($urandom), "rnd_wr");
      else        read_check(a, "rnd_rd");
    end

    // Drain with a bounded wait
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain got=%0d_pending expected=0_pending", exp_q.size());
    end
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
